// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply or restoring divide with pipeline stall.
// Optional MULDIV_EARLY_OUT_EN: divide-by-zero, signed overflow and zero-operand multiplies finish in one cycle.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            StartE,
  input  logic [2:0]      funct3E,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic            FlushE,
  output logic            StallMDE,
  output logic            DoneE,
  output logic [XLEN-1:0] ResultMDE
);

  localparam int CntW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} stateT;
  stateT state, nextState;

  logic [CntW-1:0]   count;
  logic [2:0]        opReg;
  logic              negRes, divZero;
  logic [XLEN-1:0]   opB;
  logic [2*XLEN-1:0] acc, accNext;
  logic              start, lastIter, earlyOut;
  logic              aSigned, bSigned, negStart;
  logic [XLEN-1:0]   aMag, bMag, addend;
  logic [XLEN:0]     mulSum, divShift, divDiff;

  function automatic logic [XLEN-1:0] magnitude(input logic signed [XLEN-1:0] v, input logic isSigned);
    return (isSigned && v[XLEN-1]) ? -v : v;
  endfunction

  // acc holds {high, low} product for multiplies and {remainder, quotient} for divides
  function automatic logic [XLEN-1:0] finalize(input logic [2:0] op, input logic [2*XLEN-1:0] raw,
                                               input logic neg, input logic zeroDiv);
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem;
    prod = neg ? -raw : raw;
    quo  = neg ? -raw[XLEN-1:0] : raw[XLEN-1:0];
    rem  = neg ? -raw[2*XLEN-1:XLEN] : raw[2*XLEN-1:XLEN];
    case (op)
      3'b000:         return prod[XLEN-1:0];
      3'b100, 3'b101: return zeroDiv ? '1 : quo;
      3'b110, 3'b111: return rem;
      default:        return prod[2*XLEN-1:XLEN];
    endcase
  endfunction

  function automatic logic [XLEN-1:0] shortcut(input logic [2:0] op, input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    if (!op[2]) return '0;
    if (b == '0) return op[1] ? a : '1;
    return op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  endfunction

  assign start    = (state == IDLE) && StartE && !FlushE;
  assign lastIter = (count == CntW'(XLEN - 1));

  always_comb begin
    aSigned  = 1'b0;
    bSigned  = 1'b0;
    negStart = 1'b0;
    case (funct3E)
      3'b001, 3'b100: begin
        aSigned  = 1'b1;
        bSigned  = 1'b1;
        negStart = SrcAE[XLEN-1] ^ SrcBE[XLEN-1];
      end
      3'b010: begin
        aSigned  = 1'b1;
        negStart = SrcAE[XLEN-1];
      end
      3'b110: begin
        aSigned  = 1'b1;
        bSigned  = 1'b1;
        negStart = SrcAE[XLEN-1];
      end
      default: ;
    endcase
  end

  assign aMag = magnitude(SrcAE, aSigned);
  assign bMag = magnitude(SrcBE, bSigned);

`ifdef MULDIV_EARLY_OUT_EN
  assign earlyOut = funct3E[2]
      ? ((SrcBE == '0) || (!funct3E[0] && SrcAE == {1'b1, {(XLEN-1){1'b0}}} && SrcBE == '1))
      : ((SrcAE == '0) || (SrcBE == '0));
`else
  assign earlyOut = 1'b0;
`endif

  always_comb begin
    addend   = acc[0] ? opB : '0;
    mulSum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, addend};
    divShift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    divDiff  = divShift - {1'b0, opB};
    if (state == MUL)
      accNext = {mulSum, acc[XLEN-1:1]};
    else if (divShift >= {1'b0, opB})
      accNext = {divDiff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    else
      accNext = {divShift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:     if (start) nextState = earlyOut ? DONE : (funct3E[2] ? DIV : MUL);
      MUL, DIV: if (FlushE) nextState = IDLE;
                else if (lastIter) nextState = DONE;
      DONE:     nextState = IDLE;
      default:  nextState = IDLE;
    endcase
  end

  always_comb begin
    StallMDE = 1'b0;
    DoneE    = 1'b0;
    case (state)
      IDLE:     StallMDE = start;
      MUL, DIV: StallMDE = !FlushE;
      DONE:     DoneE    = !FlushE;
      default:  ;
    endcase
  end

  // Result is written only on the final iteration (or at start for early-out) and otherwise held
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count     <= '0;
      opReg     <= '0;
      negRes    <= 1'b0;
      divZero   <= 1'b0;
      opB       <= '0;
      acc       <= '0;
      ResultMDE <= '0;
    end else if (start) begin
      count   <= '0;
      opReg   <= funct3E;
      negRes  <= negStart;
      divZero <= (SrcBE == '0);
      opB     <= bMag;
      acc     <= {{XLEN{1'b0}}, aMag};
      if (earlyOut) ResultMDE <= shortcut(funct3E, SrcAE, SrcBE);
    end else if ((state == MUL || state == DIV) && !FlushE) begin
      count <= count + CntW'(1);
      acc   <= accNext;
      if (lastIter) ResultMDE <= finalize(opReg, accNext, negRes, divZero);
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed RV32M cases, flush/reset aborts, randomized ops vs a 64-bit arithmetic model.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        StartE = 1'b0;
  logic        FlushE = 1'b0;
  logic [2:0]  funct3E = 3'd0;
  logic [31:0] SrcAE = 32'd0;
  logic [31:0] SrcBE = 32'd0;
  logic        StallMDE, DoneE;
  logic [31:0] ResultMDE;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] lastRes = 32'd0;

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EarlyOut = 1'b1;
`else
  localparam bit EarlyOut = 1'b0;
`endif

  always #5 clk = ~clk;

  muldiv_sequencer dut (
    .clk(clk), .reset_n(reset_n), .StartE(StartE), .funct3E(funct3E),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .FlushE(FlushE),
    .StallMDE(StallMDE), .DoneE(DoneE), .ResultMDE(ResultMDE)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] refModel(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFFFFFF; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFFFFFF; p = ua / ub; return p[31:0]; end
      3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  function automatic int expLatency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    bit shortOp;
    shortOp = f[2] ? (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))
                   : (a == 0 || b == 0);
    return (EarlyOut && shortOp) ? 1 : 33;
  endfunction

  // Start one op at the next cycle; optionally flush or reset at a given busy cycle (0 = never)
  task automatic doOp(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp, input int flushAt, input int resetAt);
    int cyc;
    bit done;
    int lat;
    lat = expLatency(f, a, b);
    @(posedge clk); #1;
    StartE = 1'b1; FlushE = 1'b0; funct3E = f; SrcAE = a; SrcBE = b;
    @(negedge clk);
    check("stall_c0", 32'(StallMDE), 32'd1);
    check("done_c0", 32'(DoneE), 32'd0);
    check("hold_c0", ResultMDE, lastRes);
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      StartE = 1'b0;
      funct3E = 3'($urandom_range(0, 7));
      SrcAE = $urandom;
      SrcBE = $urandom;
      cyc++;
      if (cyc == resetAt) begin
        #2 reset_n = 1'b0;
        #1;
        check("rst_stall", 32'(StallMDE), 32'd0);
        check("rst_done", 32'(DoneE), 32'd0);
        check("rst_result", ResultMDE, 32'd0);
        lastRes = 32'd0;
        return;
      end
      FlushE = (cyc == flushAt);
      @(negedge clk);
      if (cyc == flushAt) begin
        check("flush_stall", 32'(StallMDE), 32'd0);
        check("flush_done", 32'(DoneE), 32'd0);
        return;
      end
      if (DoneE) begin
        done = 1'b1;
        check("latency", 32'(cyc), 32'(lat));
        check("result", ResultMDE, exp);
        check("stall_done", 32'(StallMDE), 32'd0);
        lastRes = exp;
      end else begin
        check("stall_busy", 32'(StallMDE), 32'd1);
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $error("FAIL timeout: DoneE not seen after %0d cycles, required latency %0d", cyc, lat);
    end
  endtask

  logic [2:0]  dF [12] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6};
  logic [31:0] dA [12] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFEC, 32'hFFFFFFEC,
                           32'd100, 32'd100, 32'd5, 32'd5, 32'h80000000, 32'h80000000};
  logic [31:0] dB [12] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd3, 32'd3,
                           32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic [31:0] dE [12] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFA, 32'hFFFFFFFE,
                           32'd14, 32'd2, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};

  initial begin
    logic [2:0]  rf;
    logic [31:0] ra, rb;
    int          sel;

    repeat (3) @(negedge clk);
    check("reset_stall", 32'(StallMDE), 32'd0);
    check("reset_done", 32'(DoneE), 32'd0);
    check("reset_result", ResultMDE, 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 12; i++) doOp(dF[i], dA[i], dB[i], dE[i], 0, 0);

    doOp(3'd5, 32'd1000, 32'd7, 32'd0, 10, 0);
    doOp(3'd0, 32'd3, 32'd4, 32'd12, 0, 0);

    doOp(3'd0, 32'h12345678, 32'h9ABCDEF1, 32'd0, 0, 15);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    doOp(3'd5, 32'd9, 32'd2, 32'd4, 0, 0);

    for (int i = 0; i < 30; i++) begin
      rf  = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0: rb = 32'd0;
        1: ra = 32'd0;
        2: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        3: begin ra = $urandom_range(0, 50); rb = $urandom_range(0, 50); end
        default: ;
      endcase
      doOp(rf, ra, rb, refModel(rf, ra, rb), 0, 0);
    end

    @(negedge clk);
    check("done_single_cycle", 32'(DoneE), 32'd0);
    check("final_hold", ResultMDE, lastRes);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
